fetch_unit: RTL

- Instruction-fetch stage of the Tinker CPU, directly upstream of decode.
- Owns the PC and drives the RAM instruction read port (r_addr / r_data_out / r_error).
- Buffers fetched words in a small FIFO and hands {instruction, PC} to decode over a valid/ready handshake.
- Accepts redirects from execute (branch/jump/return) and a halt request; flags fetch faults.

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the RAM read port, buffers fetched
// words in a small FIFO and hands {instruction, pc} to decode.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h2000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] r_addr,
    input  logic [31:0] r_data_out,
    input  logic        r_error,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        error,
    output logic [1:0]  fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [63:0]   tag_pc;
    logic          inflight;
    logic [31:0]   mem_inst [DEPTH];
    logic [63:0]   mem_pc   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          in_run;
    logic          pop;
    logic [CW-1:0] occ;
    logic          ret_ok;
    logic          ret_err;
    logic          want_issue;
    logic          mis_err;
    logic          issue;
    logic          flush;
    logic          take_redirect;
    logic          push;

    // Decode handshake: an entry transfers on a rising edge where inst_valid && inst_ready;
    // instruction/inst_pc hold the FIFO head and stay stable until that transfer.
    assign inst_valid  = (count != '0);
    assign instruction = inst_valid ? mem_inst[rd_ptr] : '0;
    assign inst_pc     = inst_valid ? mem_pc[rd_ptr]   : '0;
    assign r_addr      = pc;
    assign fsm_state   = state;

    assign in_run  = (state == RUN);
    assign pop     = inst_valid && inst_ready;
    assign ret_ok  = in_run && inflight && !r_error;
    assign ret_err = in_run && inflight && r_error;

    // A slot freed by this cycle's pop counts as credit, so a draining FIFO sustains 1/cycle.
    assign occ        = count + CW'(inflight) - CW'(pop);
    assign want_issue = in_run && (occ < CW'(DEPTH)) && !redirect_valid && !halt_req && !ret_err;
    assign mis_err    = want_issue && (pc[1:0] != 2'b00);
    assign issue      = want_issue && !mis_err;

    assign flush         = in_run && !ret_err && (halt_req || redirect_valid);
    assign take_redirect = in_run && !ret_err && !halt_req && redirect_valid;
    assign push          = ret_ok && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            tag_pc   <= '0;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted   <= 1'b0;
            error    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_pc <= pc;
                pc     <= pc + 64'd4;
            end else if (take_redirect) begin
                pc <= redirect_pc;
            end

            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_inst[wr_ptr] <= r_data_out;
                    mem_pc[wr_ptr]   <= tag_pc;
                    wr_ptr           <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end

            // HALTED and ERROR are terminal until reset.
            if (in_run) begin
                if (ret_err || mis_err) begin
                    state <= ERROR;
                    error <= 1'b1;
                end else if (halt_req) begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
            end
        end
    end
endmodule
